// File: rtl/rx_buffer_pkg.sv
// Shared widths and entry layout for the UART receive buffer.
// The Tx path reuses the same FIFO geometry.
package rx_buffer_pkg;

    localparam int unsigned MAX_UART_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH      = 16;
    localparam int unsigned FIFO_ADDR_W     = 4;
    localparam int unsigned RX_ENTRY_W      = MAX_UART_DATA_W + 2;
    localparam int unsigned RX_ENT_PERR     = MAX_UART_DATA_W;
    localparam int unsigned RX_ENT_SERR     = MAX_UART_DATA_W + 1;

    // Bit layout matches RX_ENT_SERR / RX_ENT_PERR above.
    typedef struct packed {
        logic                       stop_err;
        logic                       parity_err;
        logic [MAX_UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_buffer_if.sv
// Rx-stage capture and register-side read signals of the receive buffer.
// The master side drives stimulus and reads; the slave side is the buffer itself.
interface rx_buffer_if;
    import rx_buffer_pkg::*;

    logic                       rx_done_i;
    logic [MAX_UART_DATA_W-1:0] rx_data_i;
    logic                       rx_parity_err_i;
    logic                       rx_stop_err_i;
    logic                       rd_en_i;
    logic                       flush_i;
    logic                       clr_overrun_i;
    logic [FIFO_ADDR_W:0]       thresh_i;

    logic                       rd_valid_o;
    logic [MAX_UART_DATA_W-1:0] rd_data_o;
    logic                       rd_parity_err_o;
    logic                       rd_stop_err_o;
    logic                       full_o;
    logic [FIFO_ADDR_W:0]       count_o;
    logic                       overrun_o;
    logic                       rx_irq_o;

    modport master (
        output rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i,
               rd_en_i, flush_i, clr_overrun_i, thresh_i,
        input  rd_valid_o, rd_data_o, rd_parity_err_o, rd_stop_err_o,
               full_o, count_o, overrun_o, rx_irq_o
    );

    modport slave (
        input  rx_done_i, rx_data_i, rx_parity_err_i, rx_stop_err_i,
               rd_en_i, flush_i, clr_overrun_i, thresh_i,
        output rd_valid_o, rd_data_o, rd_parity_err_o, rd_stop_err_o,
               full_o, count_o, overrun_o, rx_irq_o
    );

endinterface

// File: rtl/rx_buffer_sync_fifo.sv
// Generic first-word-fall-through circular FIFO with wrap-bit pointers and an occupancy count.
// Also exposes the next-state count so wrappers can register level flags in step with count_o.
module sync_fifo #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o,
    output logic [ADDR_W:0]   count_d_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             empty_c, full_c, pop_ok_c, push_ok_c;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop frees the slot a same-cycle push needs, so push is legal when full if it pops.
    assign pop_ok_c  = pop_i & ~empty_c & ~flush_i;
    assign push_ok_c = push_i & (~full_c | pop_ok_c) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok_c && !pop_ok_c)      count_d = count_q + PTR_W'(1);
            else if (pop_ok_c && !push_ok_c) count_d = count_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are only observable once written.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign empty_o   = empty_c;
    assign full_o    = full_c;
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/rx_buffer.sv
// UART receive buffer: one push per Rx done pulse into a FWFT FIFO,
// with sticky overrun and a fill-level interrupt.
module rx_buffer
    import rx_buffer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    rx_buffer_if.slave  bus
);

    logic                 done_q;
    logic                 overrun_q, overrun_d;
    logic                 irq_q, irq_d;
    logic                 push_c, overrun_set_c;
    logic                 fifo_empty, fifo_full;
    logic [FIFO_ADDR_W:0] fifo_count, fifo_count_d;
    logic [RX_ENTRY_W-1:0] wr_entry, rd_entry;
    rx_entry_t            head;

    // Rising edge of done: a pulse held for several clocks yields one push.
    assign push_c = bus.rx_done_i & ~done_q;

    assign wr_entry = {bus.rx_stop_err_i, bus.rx_parity_err_i, bus.rx_data_i};

    sync_fifo #(
        .WIDTH  (RX_ENTRY_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_c),
        .pop_i     (bus.rd_en_i),
        .flush_i   (bus.flush_i),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count),
        .count_d_o (fifo_count_d)
    );

    // A character is lost only when full and no same-cycle pop makes room.
    assign overrun_set_c = push_c & fifo_full & ~(bus.rd_en_i & ~fifo_empty) & ~bus.flush_i;

    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set_c)          overrun_d = 1'b1;
        else if (bus.clr_overrun_i) overrun_d = 1'b0;
        irq_d = (bus.thresh_i != '0) && (fifo_count_d >= bus.thresh_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            done_q    <= bus.rx_done_i;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign head                = rx_entry_t'(rd_entry);
    assign bus.rd_valid_o      = ~fifo_empty;
    assign bus.rd_data_o       = head.data;
    assign bus.rd_parity_err_o = head.parity_err;
    assign bus.rd_stop_err_o   = head.stop_err;
    assign bus.full_o          = fifo_full;
    assign bus.count_o         = fifo_count;
    assign bus.overrun_o       = overrun_q;
    assign bus.rx_irq_o        = irq_q;

endmodule

// File: tb/tb_rx_buffer.sv
// Directed self-checking bench for rx_buffer: edge-detected push, overrun,
// simultaneous push/pop, error flags, threshold irq, flush and async reset.
module tb_rx_buffer;
    import rx_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_buffer_if bus ();

    rx_buffer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] d, input logic pe, input logic se, input int hold);
        bus.rx_data_i       = d;
        bus.rx_parity_err_i = pe;
        bus.rx_stop_err_i   = se;
        bus.rx_done_i       = 1'b1;
        repeat (hold) tick();
        bus.rx_done_i       = 1'b0;
        bus.rx_parity_err_i = 1'b0;
        bus.rx_stop_err_i   = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, 32'(bus.rd_data_o), 32'(exp));
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
    endtask

    initial begin
        bus.rx_done_i       = 1'b0;
        bus.rx_data_i       = '0;
        bus.rx_parity_err_i = 1'b0;
        bus.rx_stop_err_i   = 1'b0;
        bus.rd_en_i         = 1'b0;
        bus.flush_i         = 1'b0;
        bus.clr_overrun_i   = 1'b0;
        bus.thresh_i        = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_valid",   32'(bus.rd_valid_o), 32'd0);
        check("rst_full",    32'(bus.full_o),     32'd0);
        check("rst_count",   32'(bus.count_o),    32'd0);
        check("rst_overrun", 32'(bus.overrun_o),  32'd0);
        check("rst_irq",     32'(bus.rx_irq_o),   32'd0);
        rst = 1'b0;
        tick();

        // 1: done held 3 clocks pushes once
        bus.rx_data_i = 8'hA5;
        bus.rx_done_i = 1'b1;
        tick();
        check("t1_count",  32'(bus.count_o),    32'd1);
        check("t1_valid",  32'(bus.rd_valid_o), 32'd1);
        check("t1_data",   32'(bus.rd_data_o),  32'hA5);
        tick();
        tick();
        check("t1_count_held", 32'(bus.count_o), 32'd1);
        bus.rx_done_i = 1'b0;
        tick();
        pop_check("t1_pop", 8'hA5);
        check("t1_empty", 32'(bus.rd_valid_o), 32'd0);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_char(8'(i), 1'b0, 1'b0, 1);
        check("t2_full",    32'(bus.full_o),    32'd1);
        check("t2_count",   32'(bus.count_o),   32'd16);
        check("t2_no_ovr",  32'(bus.overrun_o), 32'd0);
        push_char(8'hFF, 1'b0, 1'b0, 1);
        check("t2_overrun", 32'(bus.overrun_o), 32'd1);
        check("t2_count17", 32'(bus.count_o),   32'd16);
        for (int i = 0; i < 16; i++) pop_check("t2_order", 8'(i));
        check("t2_drained", 32'(bus.rd_valid_o), 32'd0);
        check("t2_notfull", 32'(bus.full_o),     32'd0);
        check("t2_ovr_sticky", 32'(bus.overrun_o), 32'd1);
        bus.clr_overrun_i = 1'b1;
        tick();
        bus.clr_overrun_i = 1'b0;
        check("t2_ovr_clr", 32'(bus.overrun_o), 32'd0);

        // 3: full FIFO, push and pop in the same clock
        for (int i = 0; i < 16; i++) push_char(8'(i), 1'b0, 1'b0, 1);
        bus.rx_data_i = 8'h55;
        bus.rx_done_i = 1'b1;
        bus.rd_en_i   = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
        bus.rd_en_i   = 1'b0;
        check("t3_count",  32'(bus.count_o),   32'd16);
        check("t3_no_ovr", 32'(bus.overrun_o), 32'd0);
        check("t3_full",   32'(bus.full_o),    32'd1);
        tick();
        for (int i = 1; i < 16; i++) pop_check("t3_order", 8'(i));
        pop_check("t3_last", 8'h55);
        check("t3_empty", 32'(bus.rd_valid_o), 32'd0);

        // 4: empty FIFO push+pop keeps the push; error flags follow the entry
        bus.rx_data_i = 8'h3C;
        bus.rx_done_i = 1'b1;
        bus.rd_en_i   = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
        bus.rd_en_i   = 1'b0;
        check("t4_count", 32'(bus.count_o),   32'd1);
        check("t4_data",  32'(bus.rd_data_o), 32'h3C);
        tick();
        push_char(8'h81, 1'b1, 1'b1, 1);
        check("t4_count2", 32'(bus.count_o), 32'd2);
        check("t4_head_perr", 32'(bus.rd_parity_err_o), 32'd0);
        pop_check("t4_pop", 8'h3C);
        check("t4_perr",  32'(bus.rd_parity_err_o), 32'd1);
        check("t4_serr",  32'(bus.rd_stop_err_o),   32'd1);
        pop_check("t4_data2", 8'h81);
        check("t4_empty", 32'(bus.count_o), 32'd0);

        // 5: threshold irq, flush beats push
        bus.thresh_i = 5'd4;
        tick();
        for (int i = 0; i < 3; i++) push_char(8'(8'h10 + i), 1'b0, 1'b0, 1);
        check("t5_irq3", 32'(bus.rx_irq_o), 32'd0);
        push_char(8'h13, 1'b0, 1'b0, 1);
        check("t5_irq4", 32'(bus.rx_irq_o), 32'd1);
        check("t5_cnt4", 32'(bus.count_o),  32'd4);
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        check("t5_irq_pop", 32'(bus.rx_irq_o), 32'd0);
        bus.flush_i   = 1'b1;
        bus.rx_data_i = 8'h77;
        bus.rx_done_i = 1'b1;
        tick();
        bus.flush_i   = 1'b0;
        check("t5_flush_cnt",   32'(bus.count_o),    32'd0);
        check("t5_flush_valid", 32'(bus.rd_valid_o), 32'd0);
        tick();
        check("t5_no_repush", 32'(bus.count_o), 32'd0);
        bus.rx_done_i = 1'b0;
        tick();
        bus.thresh_i = 5'd0;
        for (int i = 0; i < 4; i++) push_char(8'(i), 1'b0, 1'b0, 1);
        check("t5_thr0", 32'(bus.rx_irq_o), 32'd0);
        bus.thresh_i = 5'd4;
        tick();
        check("t5_thr4", 32'(bus.rx_irq_o), 32'd1);
        bus.thresh_i = 5'd17;
        tick();
        check("t5_thr17", 32'(bus.rx_irq_o), 32'd0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;

        // 6: overrun survives flush; async reset mid-burst
        for (int i = 0; i < 17; i++) push_char(8'(i), 1'b0, 1'b0, 1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("t6_flush_ovr", 32'(bus.overrun_o), 32'd1);
        check("t6_flush_cnt", 32'(bus.count_o),   32'd0);
        bus.thresh_i = 5'd4;
        for (int i = 0; i < 5; i++) push_char(8'(8'h20 + i), 1'b0, 1'b0, 1);
        check("t6_pre_cnt", 32'(bus.count_o),   32'd5);
        check("t6_pre_irq", 32'(bus.rx_irq_o),  32'd1);
        bus.rx_data_i = 8'h99;
        bus.rx_done_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid",   32'(bus.rd_valid_o), 32'd0);
        check("t6_rst_count",   32'(bus.count_o),    32'd0);
        check("t6_rst_full",    32'(bus.full_o),     32'd0);
        check("t6_rst_overrun", 32'(bus.overrun_o),  32'd0);
        check("t6_rst_irq",     32'(bus.rx_irq_o),   32'd0);
        bus.rx_done_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_cnt", 32'(bus.count_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
